// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared sizes and state encoding for the round-robin decode arbiter
package rr_arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
endpackage

// File: rtl/decoder3to8.sv
// decoder3to8: binary select to one-hot output
module decoder3to8 (
  input  logic [2:0] sel,
  output logic [7:0] Y
);
  assign Y = 8'd1 << sel;
endmodule

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter: 8-way round-robin arbiter with registered index, decoded grant and hold limit
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int HCW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             timeout
);
  state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n;
  logic [HCW-1:0] hold_cnt, cnt_n;
  logic [N_REQ-1:0] dec;
  logic to_n, rel_to, rel;
  // Scan downward so the lowest offset from ptr is written last and wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] w;
    w = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (r[p + IDX_W'(k)]) w = p + IDX_W'(k);
    return w;
  endfunction
  assign rel_to = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD - 1));
  assign rel = done || !req[grant_idx] || rel_to;
  always_comb begin
    state_n = state;
    idx_n = grant_idx;
    ptr_n = ptr;
    cnt_n = hold_cnt;
    to_n = 1'b0;
    if (state == ST_IDLE) begin
      if (|req) begin
        state_n = ST_GRANT;
        idx_n = rr_pick(req, ptr);
        cnt_n = '0;
      end
    end else if (rel) begin
      state_n = ST_IDLE;
      ptr_n = grant_idx + 3'd1;
      to_n = rel_to && !done && req[grant_idx];
    end else begin
      cnt_n = (hold_cnt == HCW'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant_idx <= '0;
      ptr <= '0;
      hold_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      grant_idx <= idx_n;
      ptr <= ptr_n;
      hold_cnt <= cnt_n;
      timeout <= to_n;
    end
  end
  decoder3to8 u_dec (.sel(grant_idx), .Y(dec));
  assign grant_valid = (state == ST_GRANT);
  assign grant = dec & {N_REQ{grant_valid}};
endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter: directed checks of reset, rotation, pointer wrap, timeout, drop and mid-grant reset
module tb_rr_decode_arbiter;
  logic clk = 1'b0;
  logic rst, done;
  logic [7:0] req, grant;
  logic grant_valid, timeout;
  logic [2:0] grant_idx;
  int vectors = 0;
  int miscompares = 0;

  rr_decode_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    tick(); tick();
    vectors++;
    if ({grant_valid, grant, grant_idx, timeout} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_state got v=%b g=%h i=%0d t=%b exp all zero", grant_valid, grant, grant_idx, timeout);
    end
    req = 8'h00; done = 1'b1;
    tick();
    vectors++;
    if ({grant_valid, grant} !== 9'h0) begin
      miscompares++;
      $display("FAIL reset_idle_done got v=%b g=%h exp v=0 g=00", grant_valid, grant);
    end
    done = 1'b0; req = 8'hFF; rst = 1'b0;
    tick();
    vectors++;
    if ({grant_valid, grant, grant_idx} !== {1'b1, 8'h01, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_first_grant got v=%b g=%h i=%0d exp v=1 g=01 i=0", grant_valid, grant, grant_idx);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    for (int i = 0; i <= 8; i++) begin
      exp = 8'd1 << (i % 8);
      vectors++;
      if ({grant_valid, grant, grant_idx} !== {1'b1, exp, 3'(i % 8)}) begin
        miscompares++;
        $display("FAIL rr_first_cycle[%0d] got v=%b g=%h i=%0d exp g=%h", i, grant_valid, grant, grant_idx, exp);
      end
      tick();
      vectors++;
      if (grant !== exp) begin
        miscompares++;
        $display("FAIL rr_second_cycle[%0d] got g=%h exp %h", i, grant, exp);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      vectors++;
      if ({grant_valid, grant, timeout, grant_idx} !== {1'b0, 8'h00, 1'b0, 3'(i % 8)}) begin
        miscompares++;
        $display("FAIL rr_bubble[%0d] got v=%b g=%h t=%b i=%0d exp idle holding idx %0d", i, grant_valid, grant, timeout, grant_idx, i % 8);
      end
      if (i == 8) req = 8'h00;
      tick();
    end
    vectors++;
    if ({grant_valid, grant} !== 9'h0) begin
      miscompares++;
      $display("FAIL rr_idle_noreq got v=%b g=%h exp idle", grant_valid, grant);
    end
  endtask

  task automatic test_pointer_wrap();
    req = 8'h20;
    tick();
    req = 8'h00;
    tick();
    vectors++;
    if ({grant_valid, timeout, grant_idx} !== {1'b0, 1'b0, 3'd5}) begin
      miscompares++;
      $display("FAIL wrap_release5 got v=%b t=%b i=%0d exp v=0 t=0 i=5", grant_valid, timeout, grant_idx);
    end
    req = 8'h05;
    tick();
    vectors++;
    if ({grant, grant_idx} !== {8'h01, 3'd0}) begin
      miscompares++;
      $display("FAIL wrap_to0 got g=%h i=%0d exp g=01 i=0", grant, grant_idx);
    end
    req = 8'h04;
    tick();
    tick();
    vectors++;
    if ({grant, grant_idx} !== {8'h04, 3'd2}) begin
      miscompares++;
      $display("FAIL wrap_next2 got g=%h i=%0d exp g=04 i=2", grant, grant_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    req = 8'h08;
    tick();
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({grant, timeout} !== {8'h08, 1'b0}) begin
        miscompares++;
        $display("FAIL to_hold[%0d] got g=%h t=%b exp g=08 t=0", c, grant, timeout);
      end
      tick();
    end
    vectors++;
    if ({grant_valid, grant, timeout} !== {1'b0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL to_pulse got v=%b g=%h t=%b exp v=0 g=00 t=1", grant_valid, grant, timeout);
    end
    tick();
    vectors++;
    if ({grant, timeout} !== {8'h08, 1'b0}) begin
      miscompares++;
      $display("FAIL to_regrant got g=%h t=%b exp g=08 t=0", grant, timeout);
    end
    tick(); tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    vectors++;
    if ({grant_valid, timeout} !== 2'b00) begin
      miscompares++;
      $display("FAIL to_done_coincide got v=%b t=%b exp v=0 t=0", grant_valid, timeout);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_req_drop();
    req = 8'h08;
    tick();
    vectors++;
    if ({grant, grant_idx} !== {8'h08, 3'd3}) begin
      miscompares++;
      $display("FAIL drop_grant3 got g=%h i=%0d exp g=08 i=3", grant, grant_idx);
    end
    req = 8'h00;
    tick();
    vectors++;
    if ({grant, timeout, grant_idx} !== {8'h00, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL drop_release got g=%h t=%b i=%0d exp g=00 t=0 i=3", grant, timeout, grant_idx);
    end
    req = 8'h19;
    tick();
    vectors++;
    if ({grant, grant_idx} !== {8'h10, 3'd4}) begin
      miscompares++;
      $display("FAIL drop_ptr4 got g=%h i=%0d exp g=10 i=4", grant, grant_idx);
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_mid_reset();
    req = 8'h20;
    tick();
    vectors++;
    if (grant !== 8'h20) begin
      miscompares++;
      $display("FAIL midrst_grant got g=%h exp 20", grant);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({grant_valid, grant, grant_idx, timeout} !== 13'h0) begin
      miscompares++;
      $display("FAIL midrst_drop got v=%b g=%h i=%0d t=%b exp all zero", grant_valid, grant, grant_idx, timeout);
    end
    req = 8'h21;
    tick();
    vectors++;
    if ({grant, grant_idx} !== {8'h01, 3'd0}) begin
      miscompares++;
      $display("FAIL midrst_ptr0 got g=%h i=%0d exp g=01 i=0", grant, grant_idx);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pointer_wrap();
    test_timeout();
    test_req_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- 8-way round-robin arbiter that shares one downstream resource between eight requesters.
- Produces a registered 3-bit grant index.
- Drives a one-hot grant vector through a 3-to-8 decoder, the same sel→Y one-hot mapping the team's decoder3to8 provides.
- Sits between requester agents and the shared resource.
- Enforces fairness and an optional maximum hold time.

Parameters:
- MAX_HOLD, 15, max consecutive cycles one owner may hold the grant; 0 = unlimited.
- HCW, $clog2(MAX_HOLD+1) (min 1), hold-counter width; derived, not to be overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, synchronous and active-high.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  current owner signals completion; ignored when no grant is active.
- grant  output  8  one-hot grant; all zero when idle.
- grant_valid  output  1  high while a grant is held.
- grant_idx  output  3  index of current owner; holds last owner when idle.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, grant=0, grant_valid=0, grant_idx=0, timeout=0, priority pointer ptr=0, hold_cnt=0.
- rst has priority over all other inputs. Asserting rst mid-grant drops the grant at that edge.
- States:
  - IDLE → GRANT when req != 0 at a clk edge.
  - GRANT → IDLE on release.
- Selection in IDLE: the winner is the first set bit of req scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
- Latency: req sampled at edge N gives grant/grant_valid/grant_idx valid after edge N, i.e. a 1-cycle registered latency.
- grant = decode(grant_idx) gated by grant_valid. It is never multi-hot and never glitches between edges.
- hold_cnt resets to 0 on entry to GRANT and increments each cycle in GRANT, saturating at MAX_HOLD.
- Release happens at an edge in GRANT when any of the following holds:
  - (a) done=1;
  - (b) req[grant_idx]=0;
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1, meaning the owner has held for MAX_HOLD cycles.
- On release:
  - grant_valid←0, grant←0.
  - ptr←grant_idx+1 (3-bit wrap: 7→0).
  - grant_idx is unchanged.
- On a release caused by (c) and by neither (a) nor (b): timeout←1 for exactly one cycle.
- If (a) and (c) coincide, no timeout pulse.
- Release always costs one idle bubble cycle. The earliest regrant is the edge after release, fixing max grant rate at one new grant per 2 cycles.
- Request changes by non-owners during GRANT are ignored until IDLE.
- done while IDLE: no effect.
- req=0 in IDLE: stay IDLE, outputs stay 0.
- Fairness: a continuously requesting agent is granted within 8 grants.

Decomposition:
- Shared package rr_arb_pkg:
  - N_REQ=8, IDX_W=3.
  - State enum {ST_IDLE, ST_GRANT}.
- Sub-module: decoder3to8 (ports sel[2:0], Y[7:0]), instantiated once.
  - sel=grant_idx; output ANDed with grant_valid.
- Priority-rotate search is a combinational function inside rr_decode_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF → grant=0, grant_valid=0, grant_idx=0, timeout=0. After release, the next edge gives grant=8'h01, grant_idx=0.
- Round robin: req=8'hFF held, done pulsed on each grant's 2nd cycle → grant sequence 01,02,04,08,10,20,40,80,01, with one idle cycle between grants.
- Pointer skip/wrap: ptr=6 (after owner 5 released), req=8'b0000_0101 → grant_idx=0 (grant=8'h01), then owner 2 next.
- Timeout: MAX_HOLD=4, req=8'h08 held, done=0 → grant=8'h08 for exactly 4 cycles, timeout=1 on the cycle after, grant=0, then regrant 8'h08.
- Request drop: owner 3 granted, req[3] deasserted → grant=0 the next cycle, no timeout, ptr=4.
- Mid-grant reset: grant=8'h20 active, rst=1 one cycle → grant=0, ptr=0. With req=8'h21 next → grant=8'h01.
